// File: rtl/multislot_recorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multislot_recorder: decimated PCM capture into NUM_SLOTS ZBT regions     |
// | with per-slot length tracking and one-shot or looped playback.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multislot_recorder #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 19,
  parameter int SLOT_BITS    = 2,
  parameter int SLOT_LOG     = 15,
  parameter int BASE_ADDR    = 0,
  parameter int DECIMATE     = 4,
  parameter int RD_LAT       = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    ready,
  input  logic                    record_req,
  input  logic                    play_req,
  input  logic                    stop_req,
  input  logic [SLOT_BITS-1:0]    slot_sel,
  input  logic                    loop_en,
  input  logic [SAMPLE_WIDTH-1:0] mic_data,
  input  logic [35:0]             zbt_rdata,
  output logic [ADDR_WIDTH-1:0]   zbt_addr,
  output logic [35:0]             zbt_wdata,
  output logic                    zbt_we_n,
  output logic [SAMPLE_WIDTH-1:0] to_ac97_data,
  output logic [1:0]              state,
  output logic                    done,
  output logic [SLOT_LOG:0]       slot_len
);

  localparam int NUM_SLOTS = 1 << SLOT_BITS;
  localparam int LEN_W     = SLOT_LOG + 1;
  localparam int CNT_W     = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam logic [LEN_W-1:0] SLOT_LEN = {1'b1, {SLOT_LOG{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATE - 1);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] RECORD = 2'b01;
  localparam logic [1:0] PLAY   = 2'b10;

  logic [1:0]           state_nxt;
  logic [SLOT_BITS-1:0] slot_q;
  logic                 loop_q;
  logic [LEN_W-1:0]     offset;
  logic [CNT_W-1:0]     cnt;
  logic [LEN_W-1:0]     lengths [NUM_SLOTS];
  logic [RD_LAT-1:0]    rd_pipe;
  logic                 done_nxt;

  logic start_rec, start_play, empty_play;
  logic wr_event, wr_commit, rec_full;
  logic rd_issue, play_end, capture;
  logic cnt_last;
  logic [LEN_W-1:0] play_len;
  logic unused_rdata;

  assign cnt_last     = (cnt == CNT_LAST);
  assign play_len     = lengths[slot_q];
  assign slot_len     = lengths[slot_sel];
  assign zbt_addr     = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({slot_q, offset[SLOT_LOG-1:0]});
  assign unused_rdata = ^zbt_rdata[35:SAMPLE_WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Event decode: stop_req outranks record_req, which outranks play_req.
  always_comb begin
    start_rec  = (state == IDLE) && record_req && !stop_req;
    start_play = (state == IDLE) && play_req && !record_req && !stop_req;
    empty_play = start_play && (lengths[slot_sel] == '0);
    wr_commit  = (state == RECORD) && !zbt_we_n;
    rec_full   = wr_commit && ((offset + LEN_W'(1)) == SLOT_LEN);
    wr_event   = (state == RECORD) && ready && cnt_last && !stop_req && !rec_full;
    rd_issue   = (state == PLAY) && ready && (cnt == '0) && !stop_req && (offset != play_len);
    // The last sample's hold ends on its final strobe; with DECIMATE=1 that is the read strobe itself.
    play_end   = (state == PLAY) && ready && cnt_last && !stop_req &&
                 ((offset == play_len) || (rd_issue && ((offset + LEN_W'(1)) == play_len)));
    capture    = (state == PLAY) && rd_pipe[RD_LAT-1];
    done_nxt   = ((state != IDLE) && stop_req) || rec_full || (play_end && !loop_q) || empty_play;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_rec)                       state_nxt = RECORD;
        else if (start_play && !empty_play)  state_nxt = PLAY;
      end
      RECORD: if (stop_req || rec_full)      state_nxt = IDLE;
      PLAY:   if (stop_req || (play_end && !loop_q)) state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zbt_we_n     <= 1'b1;
      zbt_wdata    <= '0;
      to_ac97_data <= '0;
      done         <= 1'b0;
      slot_q       <= '0;
      loop_q       <= 1'b0;
      offset       <= '0;
      cnt          <= '0;
      rd_pipe      <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) lengths[i] <= '0;
    end else begin
      done     <= done_nxt;
      zbt_we_n <= !wr_event;
      rd_pipe  <= (rd_pipe << 1) | RD_LAT'(rd_issue);
      if (wr_event) zbt_wdata <= 36'(mic_data);
      if ((state == RECORD) && ready) to_ac97_data <= mic_data;
      if (capture) to_ac97_data <= zbt_rdata[SAMPLE_WIDTH-1:0];

      if (start_rec) begin
        slot_q           <= slot_sel;
        offset           <= '0;
        cnt              <= '0;
        lengths[slot_sel] <= '0;
      end else if (start_play && !empty_play) begin
        slot_q <= slot_sel;
        loop_q <= loop_en;
        offset <= '0;
        cnt    <= '0;
      end else begin
        if ((state != IDLE) && ready) cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
        if (wr_commit) begin
          offset          <= offset + LEN_W'(1);
          lengths[slot_q] <= offset + LEN_W'(1);
        end
        if (rd_issue) offset <= offset + LEN_W'(1);
        if (play_end && loop_q) offset <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multislot_recorder.sv
`default_nettype none
// Bench for multislot_recorder: record, stop, one-shot and looped playback,
// empty-slot play and asynchronous reset, against a slot/sample reference model.
module tb_multislot_recorder;

  localparam int SW = 8, AW = 19, SB = 2, SL = 4, DEC = 4, RL = 2;

  logic          clock = 1'b0, reset_n = 1'b0;
  logic          ready = 1'b0, record_req = 1'b0, play_req = 1'b0, stop_req = 1'b0, loop_en = 1'b0;
  logic [SB-1:0] slot_sel = '0;
  logic [SW-1:0] mic_data = '0;
  logic [35:0]   zbt_rdata;
  logic [AW-1:0] zbt_addr;
  logic [35:0]   zbt_wdata;
  logic          zbt_we_n;
  logic [SW-1:0] to_ac97_data;
  logic [1:0]    state;
  logic          done;
  logic [SL:0]   slot_len;

  int compared = 0, mismatched = 0;
  int done_cnt = 0, slot3_hits = 0;

  logic [35:0]   mem [0:63];
  logic [5:0]    apipe [RL];
  logic [AW-1:0] wlog_addr [$];
  logic [35:0]   wlog_data [$];

  // Reference model: samples kept per slot, length = number kept.
  logic [7:0] stored [4][16];
  int         mlen [4];

  always #5 clock = ~clock;

  multislot_recorder #(
    .SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW), .SLOT_BITS(SB), .SLOT_LOG(SL),
    .BASE_ADDR(0), .DECIMATE(DEC), .RD_LAT(RL)
  ) dut (
    .clock(clock), .reset_n(reset_n), .ready(ready), .record_req(record_req),
    .play_req(play_req), .stop_req(stop_req), .slot_sel(slot_sel), .loop_en(loop_en),
    .mic_data(mic_data), .zbt_rdata(zbt_rdata), .zbt_addr(zbt_addr), .zbt_wdata(zbt_wdata),
    .zbt_we_n(zbt_we_n), .to_ac97_data(to_ac97_data), .state(state), .done(done),
    .slot_len(slot_len)
  );

  // ZBT model with RL-cycle read latency, plus write log and event counters.
  assign zbt_rdata = mem[apipe[RL-1]];
  always @(posedge clock) begin
    if (!zbt_we_n) begin
      mem[zbt_addr[5:0]] <= zbt_wdata;
      wlog_addr.push_back(zbt_addr);
      wlog_data.push_back(zbt_wdata);
    end
    apipe[0] <= zbt_addr[5:0];
    for (int i = 1; i < RL; i++) apipe[i] <= apipe[i-1];
    if (done) done_cnt <= done_cnt + 1;
    if (zbt_addr[5:4] == 2'd3) slot3_hits <= slot3_hits + 1;
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] m, input logic stop);
    mic_data = m; ready = 1'b1; stop_req = stop;
    tick();
    ready = 1'b0; stop_req = 1'b0;
    repeat ($urandom_range(3, 8)) tick();
  endtask

  initial begin
    int base, d0, h0, rcnt;
    logic rec_active;
    logic [7:0] m, last_mon;

    // Reset state
    repeat (2) tick();
    check("rst_state", state, 0);
    check("rst_we_n", zbt_we_n, 1);
    check("rst_addr", zbt_addr, 0);
    check("rst_wdata", zbt_wdata, 0);
    check("rst_out", to_ac97_data, 0);
    check("rst_done", done, 0);
    check("rst_len", slot_len, 0);
    reset_n = 1'b1;
    tick();

    // 1: fill slot 2, mic_data = strobe index
    slot_sel = 2'd2; record_req = 1'b1; tick(); record_req = 1'b0;
    check("t1_state_rec", state, 1);
    base = wlog_addr.size(); d0 = done_cnt; mlen[2] = 0; rec_active = 1'b1; rcnt = 0; last_mon = 8'h00;
    for (int i = 0; i < 80; i++) begin
      strobe(8'(i), 1'b0);
      if (rec_active) begin
        last_mon = 8'(i);
        if (rcnt % DEC == DEC - 1) begin
          stored[2][mlen[2]] = 8'(i); mlen[2]++;
          if (mlen[2] == 16) rec_active = 1'b0;
        end
        rcnt++;
      end
    end
    check("t1_nwrites", wlog_addr.size() - base, 16);
    for (int k = 0; k < mlen[2]; k++) begin
      check("t1_addr", wlog_addr[base+k], 2 * 16 + k);
      check("t1_data", wlog_data[base+k], {28'h0, stored[2][k]});
    end
    check("t1_done", done_cnt - d0, 1);
    check("t1_state", state, 0);
    check("t1_len", slot_len, 16);
    check("t1_monitor", to_ac97_data, last_mon);

    // 2: record slot 1 with random data; stop coincides with what would be the 6th write
    slot_sel = 2'd1; record_req = 1'b1; tick(); record_req = 1'b0;
    base = wlog_addr.size(); d0 = done_cnt; mlen[1] = 0; rec_active = 1'b1; rcnt = 0;
    for (int i = 0; i < 32; i++) begin
      m = 8'($urandom);
      strobe(m, i == 23);
      if (rec_active) begin
        if (i == 23) rec_active = 1'b0;
        else if (rcnt % DEC == DEC - 1) begin stored[1][mlen[1]] = m; mlen[1]++; end
        rcnt++;
      end
    end
    check("t2_nwrites", wlog_addr.size() - base, 5);
    for (int k = 0; k < mlen[1]; k++) begin
      check("t2_addr", wlog_addr[base+k], 1 * 16 + k);
      check("t2_data", wlog_data[base+k], {28'h0, stored[1][k]});
    end
    check("t2_done", done_cnt - d0, 1);
    check("t2_state", state, 0);
    check("t2_len1", slot_len, mlen[1]);
    slot_sel = 2'd2; #1;
    check("t2_len2", slot_len, mlen[2]);

    // 3: one-shot playback of slot 1
    slot_sel = 2'd1; loop_en = 1'b0; play_req = 1'b1; tick(); play_req = 1'b0;
    check("t3_state_play", state, 2);
    d0 = done_cnt;
    for (int j = 0; j < DEC * mlen[1]; j++) begin
      strobe(8'($urandom), 1'b0);
      check("t3_out", to_ac97_data, stored[1][j / DEC]);
      if (j == DEC * mlen[1] - 2) begin
        check("t3_no_done_yet", done_cnt - d0, 0);
        check("t3_still_play", state, 2);
      end
    end
    check("t3_done", done_cnt - d0, 1);
    check("t3_state", state, 0);
    repeat (5) tick();
    check("t3_hold", to_ac97_data, stored[1][mlen[1]-1]);

    // 4: looped playback, then stop
    loop_en = 1'b1; play_req = 1'b1; tick(); play_req = 1'b0; loop_en = 1'b0;
    d0 = done_cnt;
    for (int j = 0; j < 50; j++) begin
      strobe(8'($urandom), 1'b0);
      check("t4_out", to_ac97_data, stored[1][(j / DEC) % mlen[1]]);
    end
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_state_play", state, 2);
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    check("t4_stop_state", state, 0);
    tick();
    check("t4_done", done_cnt - d0, 1);

    // 5: play an empty slot
    h0 = slot3_hits;
    slot_sel = 2'd3; play_req = 1'b1; tick(); play_req = 1'b0;
    check("t5_done_hi", done, 1);
    check("t5_state", state, 0);
    tick();
    check("t5_done_lo", done, 0);
    repeat (4) tick();
    check("t5_no_slot3_addr", slot3_hits - h0, 0);
    check("t5_len", slot_len, 0);

    // 6: record wins over play; async reset mid-write
    slot_sel = 2'd0; record_req = 1'b1; play_req = 1'b1; tick();
    record_req = 1'b0; play_req = 1'b0;
    check("t6_state_rec", state, 1);
    for (int i = 0; i < DEC - 1; i++) strobe(8'($urandom), 1'b0);
    mic_data = 8'hA5; ready = 1'b1; tick(); ready = 1'b0;
    check("t6_we_low", zbt_we_n, 0);
    #2 reset_n = 1'b0;
    #1;
    check("t6_we_async", zbt_we_n, 1);
    check("t6_state", state, 0);
    for (int s = 0; s < 4; s++) begin
      slot_sel = 2'(s); #1;
      check("t6_len_clear", slot_len, 0);
    end
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_state_after", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multislot_recorder.md
Name: multislot_recorder

Overview:
- Parametrised successor to the single-slot AC97 capture block.
- Records decimated microphone PCM into one of NUM_SLOTS fixed-size regions of ZBT memory, tracking each slot's recorded length.
- Plays any slot back to the AC97 output, once or looped.
- Sits between the AC97 interface (ready strobe, 8-bit PCM) and the ZBT arbiter port.

Parameters:
- SAMPLE_WIDTH, 8, PCM sample width in and out.
- ADDR_WIDTH, 19, ZBT address width.
- SLOT_BITS, 2, log2 of slot count; NUM_SLOTS = 2**SLOT_BITS.
- SLOT_LOG, 15, log2 of words per slot; SLOT_LEN = 2**SLOT_LOG. Requires SLOT_BITS+SLOT_LOG <= ADDR_WIDTH.
- BASE_ADDR, 0, ZBT word address of slot 0; must be a multiple of NUM_SLOTS*SLOT_LEN.
- DECIMATE, 4, ready strobes per stored sample (>=1).
- RD_LAT, 2, ZBT read latency in clocks.

Ports:
- clock  in  1  system clock (27 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- ready  in  1  one-clock AC97 sample strobe.
- record_req  in  1  pulse: start recording into slot_sel.
- play_req  in  1  pulse: start playback of slot_sel.
- stop_req  in  1  pulse: abort current operation.
- slot_sel  in  SLOT_BITS  target slot, sampled on an accepted request.
- loop_en  in  1  sampled at play start; 1 = wrap playback.
- mic_data  in  SAMPLE_WIDTH  PCM from mic.
- zbt_rdata  in  36  ZBT read data.
- zbt_addr  out  ADDR_WIDTH  ZBT word address.
- zbt_wdata  out  36  write data = mic sample zero-extended.
- zbt_we_n  out  1  ZBT write enable, active low.
- to_ac97_data  out  SAMPLE_WIDTH  PCM to headphone.
- state  out  2  00 IDLE, 01 RECORD, 10 PLAY.
- done  out  1  one-clock pulse when RECORD or PLAY ends, for any reason.
- slot_len  out  SLOT_LOG+1  recorded length of the slot currently addressed by slot_sel.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; zbt_we_n=1; zbt_addr=BASE_ADDR; zbt_wdata=0; to_ac97_data=0; done=0.
  - All per-slot lengths=0; decimation counter=0; offset=0.
- Address: zbt_addr = BASE_ADDR + {slot, offset[SLOT_LOG-1:0]}, where slot is the latched slot.
- Request priority when several are asserted together: stop_req > record_req > play_req.
- In IDLE, stop_req is a no-op. Outside IDLE, record_req and play_req are ignored; stop_req returns to IDLE and pulses done next cycle.
- IDLE->RECORD on record_req:
  - Latch slot; offset=0; counter=0; set that slot's length to 0.
- RECORD:
  - Monitor path: each ready copies mic_data to to_ac97_data.
  - On ready with counter==DECIMATE-1: counter=0; zbt_wdata=mic_data; zbt_we_n=0 for exactly one clock at the current offset; then offset+1 and length=offset+1.
  - Otherwise on ready: counter+1.
  - zbt_we_n=1 on every other cycle.
  - When length reaches SLOT_LEN, go to IDLE and pulse done. No write ever wraps into the next slot.
  - On stop_req: length keeps the samples written so far. A write strobe in the same cycle as stop_req is suppressed.
- IDLE->PLAY on play_req:
  - Latch slot and loop_en; offset=0; counter=0.
  - If the slot length is 0: go to IDLE and pulse done next cycle, with no reads.
- PLAY:
  - On ready with counter==0: present zbt_addr for the current offset (zbt_we_n stays 1), then offset+1.
  - RD_LAT clocks later, capture zbt_rdata[SAMPLE_WIDTH-1:0] into to_ac97_data.
  - Each sample is held for DECIMATE ready strobes (sample-and-hold upsampling).
  - After the read of offset==length-1, the end-of-slot action occurs once that sample's hold period completes:
    - loop=1: offset=0 and playback continues seamlessly.
    - loop=0: go to IDLE and pulse done.
- to_ac97_data holds its last value in IDLE.
- slot_len is combinational from the length table indexed by the live slot_sel; during RECORD of that slot it shows the growing count.
- Reset mid-operation aborts immediately, drives zbt_we_n=1 asynchronously, and clears all lengths.

Test Plan:
1. Defaults with SLOT_LOG=4, DECIMATE=4: record_req slot 2, 80 ready strobes with mic_data=strobe index -> 16 writes at addresses 32..47, data 3,7,...,63; done pulse; slot_len(slot 2)=16; state=IDLE.
2. Record slot 1, stop_req after 5 writes -> slot_len=5, done pulses, no further zbt_we_n=0, slot 2 length unchanged.
3. Play slot 1 with loop_en=0 and ZBT model RD_LAT=2 -> to_ac97_data steps through the 5 stored values, each held 4 strobes; done after the 20th strobe.
4. Play the same slot with loop_en=1 for 50 strobes -> sequence repeats with period 20 strobes, no done; stop_req -> IDLE and done.
5. play_req on an empty slot 3 -> done one cycle later; zbt_addr never presents slot 3.
6. record_req and play_req in the same cycle -> RECORD; reset_n low mid-record -> zbt_we_n=1 immediately, all slot_len=0, state=IDLE.
